mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Round-robin arbiter and sequencer that shares one unsigned shift-add multiplier engine among N requesters (for example, the DDS amplitude-scaling channels). Each requester presents operands with a level request. The block grants one requester at a time and runs the M-step shift-add sequence. It returns the product on a shared result bus with a one-hot done pulse to the owner. It contains its own start/done-controlled multiply datapath, so it has no free-running multiplier timing to track.

## Interface
- `M`, default 12: operand width; product width is 2M.
- `N`, default 4: number of requesters; N >= 2.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  N: level request per requester.
- `a_in`  in  N*M: packed multiplicands; requester i uses bits [i*M +: M].
- `b_in`  in  N*M: packed multipliers; same packing.
- `grant`  out  N: one-hot, one-cycle pulse; the winner's operands were captured on the preceding edge.
- `done`  out  N: one-hot, one-cycle pulse; `result` is valid for that requester.
- `result`  out  2M: unsigned a*b; holds until the next done.
- `busy`  out  1: high whenever state != IDLE.

## Operation
- States: IDLE, RUN, DONE. Reset and default state is IDLE.
- **IDLE:**
  - `req` is sampled only in this state.
  - If any bit is set, the winner is the first set bit searching from `ptr`, `ptr+1`, … mod N.
  - On that edge: capture `a_in`/`b_in` of the winner, set `acc = {(M+1)'b0, a}`, `cnt = 0`, `grant = onehot(winner)`, store `owner`, go to RUN.
  - No request: stay in IDLE; all outputs idle.
- **RUN:** one step per edge.
  - If `acc[0]` is set: `acc = {({1'b0,acc[2M-1:M]} + {1'b0,b}), acc[M-1:0]} >> 1`.
  - Otherwise: `acc = acc >> 1`.
  - Step arithmetic is M+1 bits wide, so carry is never lost.
  - `cnt` increments each step. After the step taken with `cnt == M-1`, go to DONE.
- **DONE:**
  - `result <= acc[2M-1:0]`, `done <= onehot(owner)`, `ptr <= (owner+1) mod N`, go to IDLE.
- `grant` and `done` are cleared on the edge after they are asserted. They are never high for more than one cycle, and never both high together.
- Requester rules:
  - Hold `req` and operands stable until `grant` is seen.
  - Operands may change after `grant`.
  - `req` still high when the block returns to IDLE is a new request and competes normally.
  - Dropping `req` before it is sampled withdraws it; no grant is issued.
- Fairness: after serving i, requester i has lowest priority. Each continuously requesting requester is served at least once per N operations.
- Reset, asynchronous, at any time including mid-RUN:
  - state=IDLE, `grant`=0, `done`=0, `result`=0, `busy`=0, `ptr`=0, `cnt`=0, `acc`=0.
  - The in-flight operation is discarded; no done is issued for it.
- Zero operands are legal and produce 0. The maximum product (2^M-1)^2 is exact in 2M bits.

## Timing
- Edge E0 (IDLE, req seen): capture; `grant` and `busy` high during cycle E0..E1.
- Edges E1..EM: M shift-add steps. Edge EM moves the state to DONE.
- Edge E(M+1): `result`/`done` registered; `done` high during cycle E(M+1)..E(M+2); state IDLE.
- Edge E(M+2): the earliest next sample of `req`.
- Grant-to-done latency: M+1 cycles (13 for M=12). Back-to-back throughput: one product per M+2 cycles.
- `busy` is high from E0 until E(M+1), and low in the cycle `done` is high.
- A request asserted while busy waits and is arbitrated at the next IDLE edge.

## Test plan
- **Single request:** req=0001, a0=3, b0=5 -> grant=0001 one cycle; done=0001 exactly 13 cycles later; result=15; busy low with done.
- **Extremes:** a=4095, b=4095 -> result=24'hFFE001. a=0, b=4095 -> 0. a=4095, b=1 -> 4095.
- **All requesting from reset:** req=1111 held, distinct operands -> grants in order 0,1,2,3,0; each done matches its owner's product; 14-cycle spacing between grants.
- **Fairness:** req0 and req2 held high continuously -> grants alternate 0,2,0,2; req1 raised mid-run -> served before 0 repeats if ptr passes it.
- **Reset mid-run:** rst pulsed 5 cycles after grant -> no done; result=0, busy=0, ptr=0. A next req=0100 is granted and computes correctly.
- **Withdrawn request:** req=0010 pulsed while busy and dropped before IDLE -> no grant to requester 1.

Source files
------------

// File: rtl/mult_share_arb.sv
// mult_share_arb
//   Shares one unsigned shift-add multiplier among N requesters using a
//   round-robin arbiter. A winner's operands are captured, M shift-add steps
//   are run, and the 2M-bit product is returned with a one-hot done pulse.
//
// Ports
//   clk     in  1     rising-edge clock
//   rst     in  1     asynchronous active-high reset
//   req     in  N     level request per requester
//   a_in    in  N*M   packed multiplicands, requester i at [i*M +: M]
//   b_in    in  N*M   packed multipliers, same packing
//   grant   out N     one-hot pulse, operands of the winner were just captured
//   done    out N     one-hot pulse, result is valid for that requester
//   result  out 2M    unsigned a*b, held until the next done
//   busy    out 1     high whenever the sequencer is not idle
module mult_share_arb #(
  parameter int M = 12,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*M-1:0]   a_in,
  input  logic [N*M-1:0]   b_in,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     done,
  output logic [2*M-1:0]   result,
  output logic             busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(M + 1);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [2*M:0]    acc_q, acc_d;
  logic [M-1:0]    b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    done_q, done_d;
  logic [2*M-1:0]  result_q, result_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [M:0]      sum;
  logic [2*M:0]    step;

  // Round-robin search starting at ptr; the first set request wins.
  always_comb begin
    int idx;
    logic [IW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      idx  = (int'(ptr_q) + k) % N;
      cand = IW'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // One shift-add step; the high-half sum is M+1 bits so the carry survives
  // the shift back into bit 2M-1.
  always_comb begin
    sum  = {1'b0, acc_q[2*M-1:M]} + {1'b0, b_q};
    step = acc_q[0] ? ({sum, acc_q[M-1:0]} >> 1) : (acc_q >> 1);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    grant_d  = '0;
    done_d   = '0;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          acc_d   = {{(M+1){1'b0}}, a_in[win_idx*M +: M]};
          b_d     = b_in[win_idx*M +: M];
          cnt_d   = '0;
          grant_d = ONE << win_idx;
          owner_d = win_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(M - 1)) state_d = DONE;
      end
      DONE: begin
        result_d = acc_q[2*M-1:0];
        done_d   = ONE << owner_q;
        // The served requester drops to lowest priority.
        ptr_d    = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb
//   Directed bench for mult_share_arb (M=12, N=4): a table of single-request
//   vectors plus hand-written sequences for round-robin order, fairness,
//   mid-run reset and a withdrawn request.
module tb_mult_share_arb;

  localparam int M = 12;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*M-1:0]   a_in;
  logic [N*M-1:0]   b_in;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic [2*M-1:0]   result;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_share_arb #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant), .done(done), .result(result), .busy(busy)
  );

  typedef struct {
    int           idx;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [2*M-1:0] prod;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [M-1:0] a, input logic [M-1:0] b);
    a_in[i*M +: M] = a;
    b_in[i*M +: M] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_grant(output logic [N-1:0] g, output int at);
    g  = '0;
    at = -1000;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant != '0) begin
        g  = grant;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic wait_done(output logic [N-1:0] d, output int at,
                           output logic [2*M-1:0] r, output logic bz);
    d  = '0;
    at = -1000;
    r  = '0;
    bz = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done != '0) begin
        d  = done;
        at = cyc;
        r  = result;
        bz = busy;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]   g, d;
    int             tg, td, prev;
    logic [2*M-1:0] r;
    logic           bz;
    int             ord_all[5];
    logic [2*M-1:0] prod_all[4];
    int             ord_fair[6];
    int             n_done, n_g1;

    vecs[0] = '{0, 12'd3,    12'd5,    24'd15};
    vecs[1] = '{1, 12'd4095, 12'd4095, 24'hFFE001};
    vecs[2] = '{2, 12'd0,    12'd4095, 24'd0};
    vecs[3] = '{3, 12'd4095, 12'd1,    24'd4095};
    vecs[4] = '{0, 12'd1234, 12'd567,  24'd699678};
    vecs[5] = '{2, 12'd2048, 12'd2,    24'd4096};

    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    tick();
    tick();
    chk("reset_grant",  64'(grant),  64'(0));
    chk("reset_done",   64'(done),   64'(0));
    chk("reset_result", 64'(result), 64'(0));
    chk("reset_busy",   64'(busy),   64'(0));
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // Single requests from the table.
    for (int v = 0; v < 6; v++) begin
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
      req = oh(vecs[v].idx);
      wait_grant(g, tg);
      chk("vec_grant", 64'(g), 64'(oh(vecs[v].idx)));
      chk("vec_busy_on_grant", 64'(busy), 64'(1));
      req  = '0;
      a_in = ~a_in;
      b_in = ~b_in;
      wait_done(d, td, r, bz);
      chk("vec_done", 64'(d), 64'(oh(vecs[v].idx)));
      chk("vec_latency", 64'(td - tg), 64'(13));
      chk("vec_result", 64'(r), 64'(vecs[v].prod));
      chk("vec_busy_with_done", 64'(bz), 64'(0));
      tick();
      chk("vec_done_pulse", 64'(done), 64'(0));
      chk("vec_result_hold", 64'(result), 64'(vecs[v].prod));
    end

    // All four requesting from reset: strict rotation, 14-cycle spacing.
    do_reset();
    ord_all  = '{0, 1, 2, 3, 0};
    prod_all = '{24'd63, 24'd20000, 24'd8190, 24'd225};
    set_ops(0, 12'd7,    12'd9);
    set_ops(1, 12'd100,  12'd200);
    set_ops(2, 12'd4095, 12'd2);
    set_ops(3, 12'd15,   12'd15);
    req  = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, tg);
      chk("all_grant", 64'(g), 64'(oh(ord_all[k])));
      if (k > 0) chk("all_spacing", 64'(tg - prev), 64'(14));
      prev = tg;
      if (k == 4) req = '0;
      wait_done(d, td, r, bz);
      chk("all_done", 64'(d), 64'(oh(ord_all[k])));
      chk("all_result", 64'(r), 64'(prod_all[ord_all[k]]));
    end

    // Fairness: 0 and 2 held, 1 raised during the third operation.
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, M'(i + 1), 12'd3);
    ord_fair = '{0, 2, 0, 1, 2, 0};
    req = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g, tg);
      chk("fair_grant", 64'(g), 64'(oh(ord_fair[k])));
      if (k == 2) req[1] = 1'b1;
      if (k == 3) req[1] = 1'b0;
      if (k == 5) req = '0;
      wait_done(d, td, r, bz);
      chk("fair_done", 64'(d), 64'(oh(ord_fair[k])));
      chk("fair_result", 64'(r), 64'((ord_fair[k] + 1) * 3));
    end

    // Serve requester 1 so the pointer sits at 2 before the reset.
    req = 4'b0010;
    wait_grant(g, tg);
    req = '0;
    wait_done(d, td, r, bz);
    chk("pre_reset_result", 64'(r), 64'(6));

    // Reset five cycles into an operation.
    set_ops(2, 12'd3, 12'd5);
    req = 4'b0100;
    wait_grant(g, tg);
    chk("midrst_grant", 64'(g), 64'(4'b0100));
    req = '0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("midrst_result_async", 64'(result), 64'(0));
    chk("midrst_busy_async",   64'(busy),   64'(0));
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done != '0) n_done++;
    end
    chk("midrst_no_done", 64'(n_done), 64'(0));
    chk("midrst_result_zero", 64'(result), 64'(0));
    // Pointer back at 0: of requesters 1 and 3, requester 1 must win.
    set_ops(1, 12'd7, 12'd6);
    req = 4'b1010;
    wait_grant(g, tg);
    chk("midrst_ptr_grant", 64'(g), 64'(4'b0010));
    req = '0;
    wait_done(d, td, r, bz);
    chk("midrst_ptr_result", 64'(r), 64'(42));
    req = 4'b0100;
    wait_grant(g, tg);
    chk("after_rst_grant", 64'(g), 64'(4'b0100));
    req = '0;
    wait_done(d, td, r, bz);
    chk("after_rst_done", 64'(d), 64'(4'b0100));
    chk("after_rst_result", 64'(r), 64'(15));

    // Withdrawn request: requester 1 pulses req while busy, then drops it.
    set_ops(0, 12'd9, 12'd9);
    req = 4'b0001;
    wait_grant(g, tg);
    chk("wd_grant", 64'(g), 64'(4'b0001));
    req = 4'b0010;
    repeat (3) tick();
    req    = '0;
    n_done = 0;
    n_g1   = 0;
    r      = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (grant[1]) n_g1++;
      if (done != '0) begin
        n_done++;
        r = result;
        d = done;
      end
    end
    chk("wd_no_grant1", 64'(n_g1), 64'(0));
    chk("wd_one_done", 64'(n_done), 64'(1));
    chk("wd_done_owner", 64'(d), 64'(4'b0001));
    chk("wd_result", 64'(r), 64'(81));
    chk("wd_idle", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
